cdc_src_queue: RTL and testbench

CDC_SRC_QUEUE -- requirements
Module: cdc_src_queue

---
 rtl/cdc_src_queue.sv | 149 ++++++++++++++
 tb/tb_cdc_src_queue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_src_queue.sv
// cdc_src_queue: source-side word queue feeding a pulse/ack CDC synchronizer.
// Optional watchdog on the ack wait is enabled by macro CDC_SRC_QUEUE_TIMEOUT_EN.
//
// Ports:
//   i_src_clk     source clock, all logic on its rising edge
//   rst_n         asynchronous active-low reset
//   i_wr_valid    producer offers i_wr_data
//   o_wr_ready    queue not full (registered pointers only)
//   i_wr_data     producer word
//   o_sync_data   word held for the synchronizer (registered)
//   o_sync_puls   one-cycle launch pulse (registered)
//   i_sync_ack    transfer-complete pulse, already in i_src_clk domain
//   o_level       queue occupancy
//   o_busy        high while a transfer or its gap cycle is in progress
//   o_timeout_err sticky "ack never came" flag (0 without the macro)

module cdc_src_queue #(
   parameter int DWIDTH  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                    i_src_clk,
   input  logic                    rst_n,
   input  logic                    i_wr_valid,
   output logic                    o_wr_ready,
   input  logic [DWIDTH-1:0]       i_wr_data,
   output logic [DWIDTH-1:0]       o_sync_data,
   output logic                    o_sync_puls,
   input  logic                    i_sync_ack,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_busy,
   output logic                    o_timeout_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      GAP
   } state_t;

   state_t            state;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DWIDTH-1:0] mem [DEPTH];
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              tmo_hit;

   // Extra MSB on each pointer tells full from empty when indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);

   assign o_wr_ready = !full;
   assign push       = i_wr_valid && !full;
   assign pop        = (state == IDLE) && !empty;
   assign o_level    = wr_ptr - rd_ptr;
   assign o_busy     = (state != IDLE);

   // Storage needs no reset: stale entries are never read while empty.
   always_ff @(posedge i_src_clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge i_src_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

`ifdef CDC_SRC_QUEUE_TIMEOUT_EN
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] tmo_cnt;
   logic          tmo_err;

   // Fires on the TIMEOUT-th WAIT_ACK cycle; a same-cycle ack wins.
   assign tmo_hit = (state == WAIT_ACK) && !i_sync_ack &&
                    (tmo_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge i_src_clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if ((state == WAIT_ACK) && !i_sync_ack && !tmo_hit) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end

   always_ff @(posedge i_src_clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_err <= 1'b0;
      end else if (tmo_hit) begin
         tmo_err <= 1'b1;
      end
   end

   assign o_timeout_err = tmo_err;
`else
   assign tmo_hit       = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   always_ff @(posedge i_src_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         o_sync_data <= '0;
         o_sync_puls <= 1'b0;
      end else begin
         o_sync_puls <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  o_sync_data <= mem[rd_ptr[AW-1:0]];
                  o_sync_puls <= 1'b1;
                  state       <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (i_sync_ack || tmo_hit) begin
                  state <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_src_queue.sv
// tb_cdc_src_queue: randomized + directed bench for cdc_src_queue
// against a queue-level reference model.

module tb_cdc_src_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_wr_valid = 1'b0;
   logic          o_wr_ready;
   logic [DW-1:0] i_wr_data = '0;
   logic [DW-1:0] o_sync_data;
   logic          o_sync_puls;
   logic          i_sync_ack = 1'b0;
   logic [2:0]    o_level;
   logic          o_busy;
   logic          o_timeout_err;

   cdc_src_queue #(
      .DWIDTH (DW),
      .DEPTH  (DEPTH),
      .TIMEOUT(TMO)
   ) dut (
      .i_src_clk    (clk),
      .rst_n        (rst_n),
      .i_wr_valid   (i_wr_valid),
      .o_wr_ready   (o_wr_ready),
      .i_wr_data    (i_wr_data),
      .o_sync_data  (o_sync_data),
      .o_sync_puls  (o_sync_puls),
      .i_sync_ack   (i_sync_ack),
      .o_level      (o_level),
      .o_busy       (o_busy),
      .o_timeout_err(o_timeout_err)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int ntot  = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ntot++;
      if (act !== exp)
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      else
         npass++;
   endtask

   // Reference model: a plain word queue plus the transfer phase.
   // phase 0 = idle, 1 = waiting for ack, 2 = gap
   logic [DW-1:0] mq[$];
   int            m_ph   = 0;
   logic [DW-1:0] m_data = '0;
   logic          m_puls = 1'b0;
   logic          m_err  = 1'b0;
   int            m_wait = 0;
   logic          m_take;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_ph   = 0;
         m_data = '0;
         m_puls = 1'b0;
         m_err  = 1'b0;
         m_wait = 0;
      end else begin
         m_take = i_wr_valid && (mq.size() < DEPTH);
         m_puls = 1'b0;
         case (m_ph)
            0: if (mq.size() > 0) begin
               m_data = mq.pop_front();
               m_puls = 1'b1;
               m_ph   = 1;
               m_wait = 0;
            end
            1: if (i_sync_ack) begin
               m_ph = 2;
            end else begin
`ifdef CDC_SRC_QUEUE_TIMEOUT_EN
               m_wait++;
               if (m_wait == TMO) begin
                  m_err = 1'b1;
                  m_ph  = 2;
               end
`endif
            end
            default: m_ph = 0;
         endcase
         if (m_take) mq.push_back(i_wr_data);
      end
   end

   // Compare process plus pulse monitor.
   logic          chk_en   = 1'b0;
   int            cyc      = 0;
   int            last_p   = -1;
   int            npulse   = 0;
   logic          saw_full = 1'b0;
   logic [DW-1:0] got[$];

   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("level", 64'(o_level), 64'(mq.size()));
         chk("wr_ready", 64'(o_wr_ready), 64'(mq.size() < DEPTH));
         chk("busy", 64'(o_busy), 64'(m_ph != 0));
         chk("puls", 64'(o_sync_puls), 64'(m_puls));
         chk("sync_data", 64'(o_sync_data), 64'(m_data));
         chk("timeout_err", 64'(o_timeout_err), 64'(m_err));
         if (o_sync_puls) begin
            got.push_back(o_sync_data);
            npulse++;
            if (last_p >= 0) chk("spacing", 64'(cyc - last_p >= 3), 64'd1);
            last_p = cyc;
         end
         if (o_level == 3'(DEPTH) && !o_wr_ready) saw_full = 1'b1;
      end
   end

   // Ack driver: automatic (fixed or random delay), manual, random spurious.
   logic auto_ack = 1'b0;
   logic rnd_dly  = 1'b0;
   logic man_ack  = 1'b0;
   logic rnd_ack  = 1'b0;
   int   cd       = 0;
   logic ack_nx;

   always @(negedge clk) begin
      #1;
      ack_nx = 1'b0;
      if (!rst_n || !auto_ack) begin
         cd = 0;
      end else begin
         if (cd > 0) begin
            cd--;
            if (cd == 0) ack_nx = 1'b1;
         end
         if (o_sync_puls) cd = rnd_dly ? int'($urandom_range(1, 6)) : 4;
      end
      if (man_ack) ack_nx = 1'b1;
      if (rnd_ack && $urandom_range(0, 15) == 0) ack_nx = 1'b1;
      i_sync_ack = ack_nx;
   end

   // Starts and ends on a falling edge; holds valid until accepted.
   task automatic push_word(input logic [DW-1:0] d);
      int t = 0;
      i_wr_valid = 1'b1;
      i_wr_data  = d;
      while (!o_wr_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("push_wait_bound", 64'(t < 200), 64'd1);
      @(negedge clk);
      i_wr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((o_busy || o_level != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("idle_wait_bound", 64'(t < 300), 64'd1);
   endtask

   task automatic drain_man();
      int t = 0;
      while ((o_busy || o_level != 0) && t < 100) begin
         man_ack = 1'b1;
         @(negedge clk);
         man_ack = 1'b0;
         @(negedge clk);
         t++;
      end
      chk("drain_bound", 64'(t < 100), 64'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_level"}, 64'(o_level), 64'd0);
      chk({tag, "_ready"}, 64'(o_wr_ready), 64'd1);
      chk({tag, "_puls"}, 64'(o_sync_puls), 64'd0);
      chk({tag, "_data"}, 64'(o_sync_data), 64'd0);
      chk({tag, "_busy"}, 64'(o_busy), 64'd0);
      chk({tag, "_err"}, 64'(o_timeout_err), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   int n0;

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single word, manual ack.
      push_word(32'hA5A5_0001);
      chk("single_puls_early", 64'(o_sync_puls), 64'd0);
      @(negedge clk);
      chk("single_puls", 64'(o_sync_puls), 64'd1);
      chk("single_data", 64'(o_sync_data), 64'hA5A5_0001);
      repeat (3) @(negedge clk);
      chk("single_puls_once", 64'(o_sync_puls), 64'd0);
      chk("single_hold", 64'(o_sync_data), 64'hA5A5_0001);
      chk("single_busy", 64'(o_busy), 64'd1);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      chk("single_gap_busy", 64'(o_busy), 64'd1);
      @(negedge clk);
      chk("single_idle_busy", 64'(o_busy), 64'd0);

      // Spurious ack while idle and empty.
      n0 = npulse;
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("spur_busy", 64'(o_busy), 64'd0);
      chk("spur_level", 64'(o_level), 64'd0);
      chk("spur_npulse", 64'(npulse - n0), 64'd0);

      // Burst of six words, ack 4 cycles after each pulse.
      auto_ack = 1'b1;
      got.delete();
      saw_full = 1'b0;
      for (int i = 1; i <= 6; i++) push_word(DW'(i));
      wait_idle();
      chk("burst_count", 64'(got.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         if (i < got.size()) chk("burst_order", 64'(got[i]), 64'(i + 1));
      chk("burst_saw_full", 64'(saw_full), 64'd1);
      auto_ack = 1'b0;

      // Simultaneous push and pop at level 3.
      push_word(32'h0000_00A0);
      push_word(32'h0000_00B0);
      push_word(32'h0000_00C0);
      push_word(32'h0000_00D0);
      @(negedge clk);
      chk("pp_level_pre", 64'(o_level), 64'd3);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      push_word(32'h0000_00E0);
      chk("pp_level", 64'(o_level), 64'd3);
      chk("pp_ready", 64'(o_wr_ready), 64'd1);
      chk("pp_puls", 64'(o_sync_puls), 64'd1);
      chk("pp_data", 64'(o_sync_data), 64'h0000_00B0);
      drain_man();

      // Reset during WAIT_ACK with two words queued.
      push_word(32'h0000_0C01);
      push_word(32'h0000_0C02);
      push_word(32'h0000_0C03);
      @(negedge clk);
      chk("mid_level", 64'(o_level), 64'd2);
      chk("mid_busy", 64'(o_busy), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("mid_rst");
      @(negedge clk);
      rst_n  = 1'b1;
      npulse = 0;
      last_p = -1;
      repeat (10) @(negedge clk);
      chk("mid_no_pulse", 64'(npulse), 64'd0);

`ifdef CDC_SRC_QUEUE_TIMEOUT_EN
      // No ack: error after TMO waiting cycles, next word still launched.
      push_word(32'h1111_0001);
      @(negedge clk);
      chk("tmo_first_puls", 64'(o_sync_puls), 64'd1);
      push_word(32'h1111_0002);
      repeat (6) @(negedge clk);
      chk("tmo_err_before", 64'(o_timeout_err), 64'd0);
      @(negedge clk);
      chk("tmo_err_set", 64'(o_timeout_err), 64'd1);
      repeat (2) @(negedge clk);
      chk("tmo_next_puls", 64'(o_sync_puls), 64'd1);
      chk("tmo_next_data", 64'(o_sync_data), 64'h1111_0002);
      chk("tmo_err_sticky", 64'(o_timeout_err), 64'd1);
      drain_man();
      chk("tmo_err_kept", 64'(o_timeout_err), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("tmo_err_cleared", 64'(o_timeout_err), 64'd0);
      rst_n  = 1'b1;
      last_p = -1;
      @(negedge clk);
`endif

      // Randomized traffic with random ack delays and stray acks.
      auto_ack = 1'b1;
      rnd_dly  = 1'b1;
      rnd_ack  = 1'b1;
      for (int i = 0; i < 800; i++) begin
         i_wr_valid = ($urandom_range(0, 2) != 0);
         i_wr_data  = $urandom;
         @(negedge clk);
      end
      i_wr_valid = 1'b0;
      rnd_ack    = 1'b0;
      wait_idle();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
